two_bit_divider: RTL

TWO_BIT_DIVIDER -- requirements
Module: two_bit_divider

---
 rtl/two_bit_divider_if.sv | 34 +++
 rtl/two_bit_divider.sv | 127 ++++++++++++
 2 files changed

// File: rtl/two_bit_divider_if.sv
// Request/result bundle for two_bit_divider: start handshake, operands and registered results.
// The master drives the request; the divider (slave) returns quotient, remainder and status.
interface two_bit_divider_if;
    logic       start;
    logic [3:0] dividend;
    logic [1:0] divisor;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       busy;
    logic       done;
    logic       dz;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  dz
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output dz
    );
endinterface

// File: rtl/two_bit_divider.sv
// Sequential 4-bit by 2-bit restoring divider, one quotient bit per clock, MSB first.
// Optional macro TWO_BIT_DIVIDER_DZ_FAST_EN: divide-by-zero completes one cycle after start with dz.
module two_bit_divider (
    input  logic             clk,
    input  logic             rst,
    two_bit_divider_if.slave bus
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] dvd_q, dvd_d;
    logic [1:0] dvs_q, dvs_d;
    logic [1:0] rem_q, rem_d;
    logic [3:0] qw_q, qw_d;
    logic [3:0] quotient_q, quotient_d;
    logic [1:0] remainder_q, remainder_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       dz_q, dz_d;

    logic [2:0] shifted;
    logic       ge;
    logic [1:0] step_rem;

    // One restoring step. dvd_q shifts left so its MSB is always the next bit to bring down.
    // The subtraction is done modulo 4: a successful step always leaves rem < divisor <= 3.
    always_comb begin
        shifted  = {rem_q, dvd_q[3]};
        ge       = (shifted >= {1'b0, dvs_q});
        step_rem = ge ? (shifted[1:0] - dvs_q) : shifted[1:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        qw_d        = qw_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dz_d        = dz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    rem_d   = 2'd0;
                    qw_d    = 4'd0;
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef TWO_BIT_DIVIDER_DZ_FAST_EN
                if (dvs_q == 2'd0) begin
                    quotient_d  = 4'hF;
                    remainder_d = dvd_q[1:0];
                    dz_d        = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end else
`endif
                begin
                    rem_d = step_rem;
                    qw_d  = {qw_q[2:0], ge};
                    dvd_d = {dvd_q[2:0], 1'b0};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        quotient_d  = {qw_q[2:0], ge};
                        remainder_d = step_rem;
                        dz_d        = 1'b0;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            dvd_q       <= 4'd0;
            dvs_q       <= 2'd0;
            rem_q       <= 2'd0;
            qw_q        <= 4'd0;
            quotient_q  <= 4'd0;
            remainder_q <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            qw_q        <= qw_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dz        = dz_q;

endmodule
